// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider producing HI/LO.
// Optional MTHI/MTLO write ports are enabled by defining MULDIV_SEQ_MTHILO_EN.
module muldiv_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_SEQ_MTHILO_EN
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic             op_div_q, b_zero, sign_q, sign_r;
  logic [WIDTH-1:0] a_raw, opnd, acc_hi, acc_lo;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (count == CW'(1)) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // acc_lo holds the multiplier (mul) or dividend/quotient (div); acc_hi the
  // product upper half or the remainder. opnd is multiplicand or divisor.
  always_comb begin
    a_mag     = (!is_unsigned && a[WIDTH-1]) ? -a : a;
    b_mag     = (!is_unsigned && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
    prod      = {acc_hi, acc_lo};
    prod_fix  = sign_q ? -prod : prod;
    quo_fix   = sign_q ? -acc_lo : acc_lo;
    rem_fix   = sign_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op_div_q <= 1'b0;
      b_zero   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= (state == FIXUP);
      case (state)
        IDLE: begin
          if (start) begin
            op_div_q <= op_div;
            a_raw    <= a;
            b_zero   <= (b == '0);
            sign_q   <= !is_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r   <= !is_unsigned && a[WIDTH-1];
            opnd     <= op_div ? b_mag : a_mag;
            acc_lo   <= op_div ? a_mag : b_mag;
            acc_hi   <= '0;
            count    <= CW'(WIDTH);
          end
`ifdef MULDIV_SEQ_MTHILO_EN
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
`endif
        end
        CALC: begin
          count <= count - 1'b1;
          if (op_div_q) begin
            acc_hi <= div_rem;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          if (op_div_q) begin
            if (b_zero) begin
              hi       <= a_raw;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi       <= rem_fix;
              lo       <= quo_fix;
              div_zero <= 1'b0;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: directed operations push expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse and checks the fixed latency.
module tb_muldiv_seq_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             op_div = 1'b0;
  logic             is_unsigned = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
`ifdef MULDIV_SEQ_MTHILO_EN
  logic             hi_wr = 1'b0;
  logic             lo_wr = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
`endif
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] hi, lo;

  muldiv_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .is_unsigned(is_unsigned), .a(a), .b(b),
`ifdef MULDIV_SEQ_MTHILO_EN
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
`endif
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_single_cycle", 64'(prev_done), 64'(0));
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("busy_at_done", 64'(busy), 64'(0));
          chk("latency_busy_cycles", 64'(busy_run), 64'(WIDTH + 1));
        end
        done_cnt++;
      end
      busy_run  = busy ? busy_run + 1 : 0;
      prev_done = done;
    end
  end

  task automatic issue(input logic d, input logic u, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] eh,
                       input logic [WIDTH-1:0] el, input logic edz, input bit push);
    exp_t e;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz;
      q.push_back(e);
    end
    op_div = d; is_unsigned = u; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div_zero", 64'(div_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    wait_done("multu_max");
    issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    wait_done("div_neg7_2");
    issue(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1);
    wait_done("div_7_neg2");
    issue(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
    wait_done("divu_zero");
    issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 1);
    wait_done("mult_minneg_sq");
    issue(1'b1, 1'b1, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 1);
    wait_done("divu_10_3");
    issue(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1);
    wait_done("mult_neg3_5");

    // Second start mid-operation must be ignored; hi/lo hold the previous result meanwhile.
    issue(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("hold_hi_during_calc", 64'(hi), 64'hFFFF_FFFF);
    chk("hold_lo_during_calc", 64'(lo), 64'hFFFF_FFF1);
    issue(1'b0, 1'b1, 32'd2, 32'd3, '0, '0, 1'b0, 0);
    wait_done("start_while_busy");

    issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1);
    wait_done("div_neg_zero");

    issue(1'b1, 1'b1, 32'd100, 32'd7, '0, '0, 1'b0, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_hi", 64'(hi), 64'(0));
    chk("async_rst_lo", 64'(lo), 64'(0));
    chk("async_rst_div_zero", 64'(div_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1);
    wait_done("mult_6_7");
    // Start driven in the cycle done is high.
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
    wait_done("div_overflow");

`ifdef MULDIV_SEQ_MTHILO_EN
    hi_wr = 1'b1; wdata = 32'hCAFE_BABE;
    @(negedge clk);
    hi_wr = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hCAFE_BABE);
    chk("mthi_lo_kept", 64'(lo), 64'h8000_0000);
    lo_wr = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    lo_wr = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1357_9BDF);
    chk("mtlo_hi_kept", 64'(hi), 64'hCAFE_BABE);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(11));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
